bp_bht: RTL

//  Direct-mapped branch target buffer with 2-bit saturating direction counters.

---
 rtl/bp_bht_pkg.sv | 23 ++
 rtl/bp_sat_ctr.sv | 19 +
 rtl/bp_bht.sv | 96 +++++++++
 3 files changed

// File: rtl/bp_bht_pkg.sv
// Shared constants for the branch target buffer: counter encodings, default
// geometry and the ctrl hold_flag codes the slot pipeline reacts to.
package bp_bht_pkg;

    localparam int          BP_CTR_W      = 2;
    localparam logic [1:0]  BP_CTR_WEAK_T = 2'b10;
    localparam logic [1:0]  BP_CTR_INIT   = 2'b01;
    localparam int          BP_ENTRIES    = 64;
    localparam int          BP_TAG_W      = 10;

    localparam logic [2:0]  HOLD_NONE = 3'b000;
    localparam logic [2:0]  HOLD_PC   = 3'b001;
    localparam logic [2:0]  HOLD_IF   = 3'b010;
    localparam logic [2:0]  HOLD_ID   = 3'b011;

    typedef enum logic [BP_CTR_W-1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } bp_ctr_e;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating up/down counter step, purely combinational.
module bp_sat_ctr
    import bp_bht_pkg::*;
(
    input  logic [BP_CTR_W-1:0] ctr,
    input  logic                inc,
    output logic [BP_CTR_W-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_STRONG_T) ctr_next = ctr + 1'b1;
        end else begin
            if (ctr != CTR_STRONG_NT) ctr_next = ctr - 1'b1;
        end
    end

endmodule

// File: rtl/bp_bht.sv
// Direct-mapped BTB with 2-bit direction counters; the prediction bit rides
// the IF/ID and ID/EX slots so ctrl sees it aligned with the instruction in EX.
module bp_bht
    import bp_bht_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int TAG_W   = BP_TAG_W
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic [2:0]  hold_flag_i,
    output logic        bp_if_o,
    output logic        bp_result_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Flop-based table so the valid bits and counters clear on async reset.
    logic                tbl_valid  [ENTRIES];
    logic [TAG_W-1:0]    tbl_tag    [ENTRIES];
    logic [31:0]         tbl_target [ENTRIES];
    logic [BP_CTR_W-1:0] tbl_ctr    [ENTRIES];

    logic [IDX_W-1:0]    fetch_idx;
    logic [TAG_W-1:0]    fetch_tag;
    logic                fetch_hit;
    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic [BP_CTR_W-1:0] upd_ctr_next;

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign fetch_tag = fetch_pc_i[TAG_W+IDX_W+1:IDX_W+2];
    assign upd_idx   = upd_pc_i[IDX_W+1:2];
    assign upd_tag   = upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i[31:TAG_W+IDX_W+2], fetch_pc_i[1:0],
                              upd_pc_i[31:TAG_W+IDX_W+2], upd_pc_i[1:0]};

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign fetch_hit     = tbl_valid[fetch_idx] && (tbl_tag[fetch_idx] == fetch_tag);
    assign pred_taken_o  = fetch_hit && tbl_ctr[fetch_idx][1];
    assign pred_target_o = pred_taken_o ? tbl_target[fetch_idx] : 32'd0;

    assign upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr      (tbl_ctr[upd_idx]),
        .inc      (upd_taken_i),
        .ctr_next (upd_ctr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= 32'd0;
                tbl_ctr[i]    <= BP_CTR_INIT;
            end
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                tbl_ctr[upd_idx] <= upd_ctr_next;
                if (upd_taken_i) tbl_target[upd_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                tbl_valid[upd_idx]  <= 1'b1;
                tbl_tag[upd_idx]    <= upd_tag;
                tbl_target[upd_idx] <= upd_target_i;
                tbl_ctr[upd_idx]    <= BP_CTR_WEAK_T;
            end
        end
    end

    // Hold_Id and above flush both slots; Hold_If flushes only IF/ID; Hold_Pc freezes IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_if_o     <= 1'b0;
            bp_result_o <= 1'b0;
        end else begin
            if (hold_flag_i >= HOLD_IF)      bp_if_o <= 1'b0;
            else if (hold_flag_i != HOLD_PC) bp_if_o <= pred_taken_o;

            if (hold_flag_i >= HOLD_ID) bp_result_o <= 1'b0;
            else                        bp_result_o <= bp_if_o;
        end
    end

endmodule
